// File: rtl/fec_cc_encoder.sv
// rtl/fec_cc_encoder.sv - tailbiting K=7 convolutional encoder with ping-pong block store and puncturing
module fec_cc_encoder #(
    parameter int         BLOCK_LEN = 96,
    parameter logic [6:0] G1        = 7'o171,
    parameter logic [6:0] G2        = 7'o133
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_data,
    input  logic [1:0] in_mode,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_data,
    output logic       out_last
);

    localparam int             PW       = $clog2(BLOCK_LEN);
    localparam logic [PW-1:0]  LAST_IDX = PW'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ENCODE} state_t;

    logic [BLOCK_LEN-1:0] mem [2];
    logic [1:0]           bank_mode [2];
    logic [1:0]           full;
    logic [1:0]           full_nxt;
    logic                 wr_bank;
    logic [PW-1:0]        wr_ptr;
    logic                 wr_fire;
    logic                 wr_done;

    state_t               state;
    logic                 rd_bank;
    logic [5:0]           sr;
    logic [PW-1:0]        idx;
    logic [1:0]           phase;
    logic                 sym;
    logic [1:0]           mode_r;

    logic                 cur_bit;
    logic [6:0]           win;
    logic                 x_bit;
    logic                 y_bit;
    logic                 two_sym;
    logic                 sel_y;
    logic                 bit_end;
    logic                 blk_end;
    logic                 phase_wrap;
    logic                 enc;
    logic                 out_fire;
    logic                 rd_done;

    assign in_ready = ~full[wr_bank];
    assign wr_fire  = in_valid & in_ready;
    assign wr_done  = wr_fire && (wr_ptr == LAST_IDX);

    always_ff @(posedge clock_50) begin
        if (wr_fire) begin
            mem[wr_bank][wr_ptr] <= in_data;
        end
    end

    // The written bank is never the full read bank, so both updates can land together.
    always_comb begin
        full_nxt = full;
        if (wr_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            full         <= '0;
            wr_bank      <= 1'b0;
            wr_ptr       <= '0;
            bank_mode[0] <= 2'd0;
            bank_mode[1] <= 2'd0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                if (wr_ptr == '0) begin
                    bank_mode[wr_bank] <= in_mode;
                end
                if (wr_done) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    assign cur_bit = mem[rd_bank][idx];
    assign win     = {cur_bit, sr};
    assign x_bit   = ^(win & G1);
    assign y_bit   = ^(win & G2);

    // Phase 1 of either punctured pattern keeps only Y, phase 2 (3/4 only) keeps only X.
    assign two_sym    = (mode_r == 2'd0) || (phase == 2'd0);
    assign sel_y      = sym | (!two_sym && (phase == 2'd1));
    assign bit_end    = two_sym ? sym : 1'b1;
    assign blk_end    = bit_end && (idx == LAST_IDX);
    assign phase_wrap = (mode_r == 2'd0) ||
                        (mode_r == 2'd1 && phase == 2'd1) ||
                        (mode_r == 2'd2 && phase == 2'd2);

    assign enc       = (state == ENCODE);
    assign out_valid = enc;
    assign out_data  = enc & (sel_y ? y_bit : x_bit);
    assign out_last  = enc & blk_end;
    assign out_fire  = enc & out_ready;
    assign rd_done   = out_fire & blk_end;

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            sr      <= '0;
            idx     <= '0;
            phase   <= 2'd0;
            sym     <= 1'b0;
            mode_r  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // Tailbiting: start from the block's own last six bits.
                    sr     <= mem[rd_bank][BLOCK_LEN-1 -: 6];
                    idx    <= '0;
                    phase  <= 2'd0;
                    sym    <= 1'b0;
                    mode_r <= (bank_mode[rd_bank] == 2'd3) ? 2'd0 : bank_mode[rd_bank];
                    state  <= ENCODE;
                end
                ENCODE: begin
                    if (out_fire) begin
                        if (!bit_end) begin
                            sym <= 1'b1;
                        end else begin
                            sym   <= 1'b0;
                            sr    <= {cur_bit, sr[5:1]};
                            phase <= phase_wrap ? 2'd0 : phase + 1'b1;
                            if (blk_end) begin
                                idx     <= '0;
                                rd_bank <= ~rd_bank;
                                state   <= IDLE;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
